// File: rtl/mod60_bcd_counter_if.sv
// mod60_bcd_counter_if: control/result bundle for one two-digit BCD counter stage.
//   en, up        count enable (cascade-in) and direction
//   load,load_val synchronous preset request and BCD value ([7:4] tens, [3:0] units)
//   units, tens   current digits
//   co            combinational cascade carry/borrow
//   load_err      one-cycle flag: previous cycle's preset was rejected
// master drives the controls; slave is the counter.
interface mod60_bcd_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] units;
  logic [3:0] tens;
  logic       co;
  logic       load_err;

  modport master (output en, up, load, load_val, input units, tens, co, load_err);
  modport slave  (input en, up, load, load_val, output units, tens, co, load_err);
endinterface

// File: rtl/mod60_bcd_counter.sv
// mod60_bcd_counter: two-digit up/down BCD counter, units mod 10, tens mod TENS_MOD.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (beats load and en)
//   bus  slave side of mod60_bcd_counter_if (en/up/load/load_val in;
//        units/tens/co/load_err out)
// co is combinational and asserted in the wrapping cycle, so a following
// stage's en can be wired straight to it.
module mod60_bcd_counter #(
  parameter int TENS_MOD = 6
) (
  input logic                   clk,
  input logic                   rst,
  mod60_bcd_counter_if.slave    bus
);

  localparam logic [3:0] TMAX = 4'(TENS_MOD - 1);

  logic [3:0] units_q, tens_q;
  logic [3:0] units_nx, tens_nx;
  logic       err_q;
  logic       load_ok;
  logic       terminal;

  assign load_ok  = (bus.load_val[3:0] <= 4'd9) && (bus.load_val[7:4] <= TMAX);
  assign terminal = bus.up ? (units_q == 4'd9 && tens_q == TMAX)
                           : (units_q == 4'd0 && tens_q == 4'd0);

  // Comparisons use >= / > so that a corrupted state still steps back into
  // the legal range instead of running past 9 or TMAX.
  always_comb begin
    units_nx = units_q;
    tens_nx  = tens_q;
    if (bus.up) begin
      if (units_q >= 4'd9) begin
        units_nx = 4'd0;
        tens_nx  = (tens_q >= TMAX) ? 4'd0 : tens_q + 4'd1;
      end else begin
        units_nx = units_q + 4'd1;
      end
    end else begin
      if (units_q == 4'd0) begin
        units_nx = 4'd9;
        if (tens_q == 4'd0)    tens_nx = TMAX;
        else if (tens_q > TMAX) tens_nx = TMAX;
        else                    tens_nx = tens_q - 4'd1;
      end else if (units_q > 4'd9) begin
        units_nx = 4'd9;
      end else begin
        units_nx = units_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      err_q   <= 1'b0;
    end else if (bus.load) begin
      err_q <= ~load_ok;
      if (load_ok) begin
        units_q <= bus.load_val[3:0];
        tens_q  <= bus.load_val[7:4];
      end
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        units_q <= units_nx;
        tens_q  <= tens_nx;
      end
    end
  end

  assign bus.units    = units_q;
  assign bus.tens     = tens_q;
  assign bus.load_err = err_q;
  assign bus.co       = bus.en & ~bus.load & ~rst & terminal;

endmodule

// File: tb/tb_mod60_bcd_counter.sv
// tb_mod60_bcd_counter: scoreboard bench. Each driven cycle pushes the expected
// next {tens,units,load_err} from a 0..59 integer model; it is popped and
// compared after the clock edge. co is checked in the driven cycle.
// A second pair of instances checks cascading (lower.co -> upper.en).
module tb_mod60_bcd_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod60_bcd_counter_if dif();
  mod60_bcd_counter_if lo_if();
  mod60_bcd_counter_if hi_if();

  mod60_bcd_counter #(.TENS_MOD(6)) dut (.clk(clk), .rst(rst), .bus(dif));
  mod60_bcd_counter #(.TENS_MOD(6)) u_lo (.clk(clk), .rst(rst), .bus(lo_if));
  mod60_bcd_counter #(.TENS_MOD(6)) u_hi (.clk(clk), .rst(rst), .bus(hi_if));

  assign lo_if.up       = 1'b1;
  assign lo_if.load     = 1'b0;
  assign lo_if.load_val = 8'h00;
  assign hi_if.en       = lo_if.co;
  assign hi_if.up       = 1'b1;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 8'h00;

  int total = 0;
  int bad   = 0;
  int mv    = 0;      // model count 0..59
  logic [8:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [7:0] lv,
                     input logic e, input logic u);
    logic       eco, merr, ok;
    logic [8:0] exp;
    rst = r; dif.load = l; dif.load_val = lv; dif.en = e; dif.up = u;
    #1;
    eco = e && !l && !r && (u ? (mv == 59) : (mv == 0));
    chk("co", {31'd0, dif.co}, {31'd0, eco});
    ok   = (lv[3:0] <= 9) && (lv[7:4] <= 5);
    merr = 1'b0;
    if (r)           mv = 0;
    else if (l) begin
      if (ok) mv = lv[7:4] * 10 + lv[3:0];
      else    merr = 1'b1;
    end else if (e)  mv = u ? (mv + 1) % 60 : (mv + 59) % 60;
    sb_q.push_back({4'(mv / 10), 4'(mv % 10), merr});
    @(posedge clk); #1;
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      exp = sb_q.pop_front();
      chk("digits", {23'd0, dif.tens, dif.units, dif.load_err}, {23'd0, exp});
    end
  endtask

  initial begin
    rst = 1'b1; dif.en = 1'b0; dif.up = 1'b1; dif.load = 1'b0; dif.load_val = 8'h00;
    lo_if.en = 1'b0;
    @(posedge clk); #1;

    // reset, then 60 up steps (wrap 59 -> 00, co only at 59)
    repeat (2) cyc(1, 0, 8'h00, 0, 1);
    repeat (60) cyc(0, 0, 8'h00, 1, 1);

    // count down with borrow from 00, then 10 -> 09
    cyc(0, 1, 8'h00, 0, 1);
    repeat (3) cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 1, 8'h10, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);

    // preset beats en, then one up step
    cyc(0, 1, 8'h45, 1, 1);
    cyc(0, 0, 8'h00, 1, 1);

    // invalid presets from 23; err lasts one cycle
    cyc(0, 1, 8'h23, 0, 1);
    cyc(0, 1, 8'h6A, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'h60, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'h5F, 0, 1);
    cyc(0, 1, 8'h59, 0, 1);
    cyc(0, 0, 8'h00, 1, 1);

    // enable gaps and direction flip from 08
    cyc(0, 1, 8'h08, 0, 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 0);

    // reset priority at 37
    cyc(0, 1, 8'h37, 0, 1);
    cyc(1, 1, 8'h12, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);

    // random mix
    for (int i = 0; i < 80; i++)
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
          8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));

    // cascade: 120 up steps on the lower stage
    repeat (2) cyc(1, 0, 8'h00, 0, 1);
    lo_if.en = 1'b1;
    repeat (120) cyc(0, 0, 8'h00, 0, 1);
    lo_if.en = 1'b0;
    chk("casc_lo", {24'd0, lo_if.tens, lo_if.units}, 32'h00);
    chk("casc_hi", {24'd0, hi_if.tens, hi_if.units}, 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
